// File: rtl/leaky_pkg.sv
// leaky_pkg: shared types and saturating arithmetic for the leaky integrate-and-fire core.
package leaky_pkg;
    localparam int LIF_WIDTH = 8;

    typedef enum logic [0:0] {INTEGRATE = 1'b0, REFRACT = 1'b1} lif_state_t;

    // Unsigned add clamped to the all-ones value of a w-bit word (w < 32).
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] max_v;
        sum   = {1'b0, a} + {1'b0, b};
        max_v = (33'd1 << w) - 33'd1;
        return (sum > max_v) ? max_v[31:0] : sum[31:0];
    endfunction
endpackage

// File: rtl/leaky_decay_sat.sv
// leaky_decay_sat: combinational leak-and-integrate, nxt = sat(state - (state >> DECAY_SHIFT) + current).
module leaky_decay_sat
    import leaky_pkg::*;
#(
    parameter int WIDTH       = LIF_WIDTH,
    parameter int DECAY_SHIFT = 1
) (
    input  logic [WIDTH-1:0] state_i,
    input  logic [WIDTH-1:0] current_i,
    output logic [WIDTH-1:0] nxt_o
);
    logic [WIDTH-1:0] leaked;

    assign leaked = state_i - (state_i >> DECAY_SHIFT);
    assign nxt_o  = WIDTH'(sat_add(32'(leaked), 32'(current_i), WIDTH));
endmodule

// File: rtl/leaky_lif_core.sv
// leaky_lif_core: one LIF neuron timestep per enabled cycle, with reset-to-zero firing
// and an optional refractory period.
module leaky_lif_core
    import leaky_pkg::*;
#(
    parameter int WIDTH         = LIF_WIDTH,
    parameter int DECAY_SHIFT   = 1,
    parameter int REFRAC_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] current_in,
    input  logic [WIDTH-1:0] threshold,
    output logic [WIDTH-1:0] state_out,
    output logic             spike_out,
    output logic [WIDTH-1:0] spike_count,
    output logic             refractory
);
    localparam int CW = (REFRAC_CYCLES > 0) ? $clog2(REFRAC_CYCLES + 1) : 1;

    lif_state_t       fsm_q, fsm_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] state_q, state_d, count_q, count_d, nxt, thr;
    logic             spike_q, spike_d, fire;

    leaky_decay_sat #(.WIDTH(WIDTH), .DECAY_SHIFT(DECAY_SHIFT)) u_decay (
        .state_i   (state_q),
        .current_i (current_in),
        .nxt_o     (nxt)
    );

    // A zero threshold would fire on an empty membrane forever; clamp it to 1.
    assign thr  = (threshold == '0) ? WIDTH'(1) : threshold;
    assign fire = (fsm_q == INTEGRATE) && (nxt >= thr);

    always_comb begin
        state_d = state_q;
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        spike_d = 1'b0;
        if (ena) begin
            if (fsm_q == REFRACT) begin
                state_d = '0;
                cnt_d   = cnt_q - 1'b1;
                fsm_d   = (cnt_q == CW'(1)) ? INTEGRATE : REFRACT;
            end else if (fire) begin
                spike_d = 1'b1;
                state_d = '0;
                count_d = count_q + 1'b1;
                fsm_d   = (REFRAC_CYCLES > 0) ? REFRACT : INTEGRATE;
                cnt_d   = CW'(REFRAC_CYCLES);
            end else begin
                state_d = nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            fsm_q   <= INTEGRATE;
            cnt_q   <= '0;
            count_q <= '0;
            spike_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            spike_q <= spike_d;
        end
    end

    assign state_out   = state_q;
    assign spike_out   = spike_q;
    assign spike_count = count_q;
    assign refractory  = (fsm_q == REFRACT);
endmodule

// File: tb/tb_leaky_lif_core.sv
// tb_leaky_lif_core: directed and random stimulus against a behavioural neuron model,
// covering a 4-step refractory core and a no-refractory core side by side.
module tb_leaky_lif_core;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [7:0] current_in = '0;
    logic [7:0] threshold = '0;
    logic [7:0] st4, cnt4, st0, cnt0;
    logic       spk4, ref4, spk0, ref0;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        int mem;
        int cnt;
        int left;
        int spk;
    } mst_t;

    mst_t m4, m0;

    always #5 clk = ~clk;

    leaky_lif_core #(.WIDTH(8), .DECAY_SHIFT(1), .REFRAC_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .current_in(current_in), .threshold(threshold),
        .state_out(st4), .spike_out(spk4), .spike_count(cnt4), .refractory(ref4)
    );

    leaky_lif_core #(.WIDTH(8), .DECAY_SHIFT(1), .REFRAC_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .current_in(current_in), .threshold(threshold),
        .state_out(st0), .spike_out(spk0), .spike_count(cnt0), .refractory(ref0)
    );

    function automatic mst_t nstep(mst_t s, bit en, int cur, int th, int r);
        mst_t o;
        int   n;
        o     = s;
        o.spk = 0;
        if (!en) return o;
        if (s.left > 0) begin
            o.mem  = 0;
            o.left = s.left - 1;
            return o;
        end
        n = s.mem - s.mem / 2 + cur;
        if (n > 255) n = 255;
        if (n >= ((th < 1) ? 1 : th)) begin
            o.spk  = 1;
            o.mem  = 0;
            o.cnt  = (s.cnt + 1) % 256;
            o.left = r;
        end else begin
            o.mem = n;
        end
        return o;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m4 <= '{default: 0};
            m0 <= '{default: 0};
        end else begin
            m4 <= nstep(m4, ena, int'(current_in), int'(threshold), 4);
            m0 <= nstep(m0, ena, int'(current_in), int'(threshold), 0);
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        cmp("state4", int'(st4), m4.mem);
        cmp("spike4", int'(spk4), m4.spk);
        cmp("count4", int'(cnt4), m4.cnt);
        cmp("refr4", int'(ref4), int'(m4.left > 0));
        cmp("state0", int'(st0), m0.mem);
        cmp("spike0", int'(spk0), m0.spk);
        cmp("count0", int'(cnt0), m0.cnt);
        cmp("refr0", int'(ref0), int'(m0.left > 0));
    end

    task automatic step(input bit e, input int c, input int t);
        ena        = e;
        current_in = 8'(c);
        threshold  = 8'(t);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int conv[7] = '{100, 150, 175, 188, 194, 197, 199};
        repeat (3) @(posedge clk);
        #1;
        cmp("rst_state", int'(st4), 0);
        cmp("rst_refr", int'(ref4), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            step(1, 100, 200);
            cmp("conv_state", int'(st4), conv[i]);
            cmp("conv_spike", int'(spk4), 0);
        end
        step(1, 100, 200);
        cmp("conv_fire", int'(spk4), 1);
        cmp("conv_zero", int'(st4), 0);
        cmp("conv_count", int'(cnt4), 1);
        cmp("conv_refr", int'(ref4), 1);

        for (int i = 0; i < 4; i++) begin
            step(1, 255, 255);
            cmp("refr_state", int'(st4), 0);
            cmp("refr_spike", int'(spk4), 0);
            cmp("refr_flag", int'(ref4), int'(i < 3));
        end
        step(1, 255, 255);
        cmp("refr_fire", int'(spk4), 1);
        cmp("refr_count", int'(cnt4), 2);

        step(1, 255, 255);
        for (int i = 0; i < 10; i++) begin
            step(0, 255, 255);
            cmp("gate_refr", int'(ref4), 1);
            cmp("gate_spike", int'(spk4), 0);
            cmp("gate_count", int'(cnt4), 2);
        end
        for (int i = 0; i < 3; i++) begin
            step(1, 255, 255);
            cmp("gate_resume", int'(ref4), int'(i < 2));
        end
        step(1, 255, 255);
        cmp("gate_fire", int'(spk4), 1);

        pulse_reset();
        for (int i = 0; i < 8; i++) step(1, 100, 255);
        cmp("sat_pre", int'(st4), 200);
        step(1, 255, 255);
        cmp("sat_fire", int'(spk4), 1);
        cmp("sat_zero", int'(st4), 0);

        pulse_reset();
        for (int i = 0; i < 256; i++) begin
            step(1, 1, 0);
            cmp("wrap_spike", int'(spk0), 1);
            cmp("wrap_count", int'(cnt0), (i + 1) % 256);
        end

        pulse_reset();
        step(1, 255, 1);
        step(1, 0, 1);
        cmp("ares_pre", int'(ref4), 1);
        #3;
        rst_n = 1'b0;
        #1;
        cmp("ares_state", int'(st4), 0);
        cmp("ares_spike", int'(spk4), 0);
        cmp("ares_count", int'(cnt4), 0);
        cmp("ares_refr", int'(ref4), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) pulse_reset();
            step($urandom_range(0, 9) < 8, int'($urandom_range(0, 255)),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(100, 255)));
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
